// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding a one-slot output register. Each cycle it picks
// one requester in rotating priority order and steers that requester's word
// out of the flattened input bus. The word is then held under valid/ready.
module rr_mux_arbiter #(
    parameter int unsigned IN   = 4,
    parameter int unsigned DATA = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN-1:0]         req,
    input  logic [IN*DATA-1:0]    flattened_input,
    output logic [IN-1:0]         gnt,
    output logic                  out_valid,
    output logic [DATA-1:0]       out_data,
    output logic [$clog2(IN)-1:0] out_sel,
    input  logic                  out_ready
);

    localparam int unsigned     SelW    = $clog2(IN);
    // After reset the pointer sits on the last channel, so channel 0 is searched first.
    localparam logic [SelW-1:0] LastRst = SelW'(IN - 1);

    logic [SelW-1:0] last_q;
    logic [SelW-1:0] winner;
    logic            load;
    logic [DATA-1:0] mux_word;

    // Load when anyone requests and the slot is empty or is being drained this
    // cycle. Gating with rst_n keeps gnt low while reset is held.
    assign load = rst_n && (|req) && (!out_valid || out_ready);

    // Rotating search: last+1, last+2, ... wrapping modulo IN, ending on last itself.
    always_comb begin
        int unsigned cand;
        logic        found;
        winner = last_q;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= IN; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= IN) begin
                cand = cand - IN;
            end
            if (!found && req[cand[SelW-1:0]]) begin
                found  = 1'b1;
                winner = cand[SelW-1:0];
            end
        end
    end

    // Flattened-bus multiplexer: select the winner's DATA-wide slice.
    always_comb begin
        mux_word = '0;
        for (int i = 0; i < int'(IN); i++) begin
            if (winner == SelW'(i)) begin
                mux_word = flattened_input[i*DATA +: DATA];
            end
        end
    end

    // One-hot grant, only in a cycle where the slot actually loads.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < int'(IN); i++) begin
            gnt[i] = load && (winner == SelW'(i));
        end
    end

    // Output slot and priority pointer. A drain without a new load empties the
    // slot but leaves the stale data and index in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last_q    <= LastRst;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mux_word;
            out_sel   <= winner;
            last_q    <= winner;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
